// File: rtl/trap_pkg.sv
// Shared constants for the trap controller: exception bit positions, cause codes, FSM state encoding.
package trap_pkg;

    localparam int EXC_W = 6;

    localparam int EXC_FETCH_MIS = 0;
    localparam int EXC_ILLEGAL   = 1;
    localparam int EXC_EBREAK    = 2;
    localparam int EXC_ECALL     = 3;
    localparam int EXC_LOAD_MIS  = 4;
    localparam int EXC_STORE_MIS = 5;

    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

    localparam logic [31:0] CAUSE_FETCH_MIS = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL     = 32'd11;
    localparam logic [31:0] CAUSE_LOAD_MIS  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MIS = 32'd6;
    localparam logic [31:0] CAUSE_IRQ_MSI   = 32'h8000_0003;
    localparam logic [31:0] CAUSE_IRQ_MTI   = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IRQ_MEI   = 32'h8000_000B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN_T,
        S_ENTER,
        S_DRAIN_M,
        S_MRET,
        S_REDIRECT
    } trap_state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder: exceptions (lowest exc_vec bit wins) ahead of enabled interrupts MEI > MSI > MTI.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [EXC_W-1:0] i_exc_vec,
    input  logic             i_irq_meip,
    input  logic             i_irq_msip,
    input  logic             i_irq_mtip,
    input  logic             i_mstatus_mie,
    input  logic [31:0]      i_mie,
    output logic             o_valid,
    output logic             o_is_irq,
    output logic [31:0]      o_cause
);

    logic w_unused_mie;
    assign w_unused_mie = ^{i_mie[31:12], i_mie[10:8], i_mie[6:4], i_mie[2:0]};

    always_comb begin
        o_valid  = 1'b1;
        o_is_irq = 1'b0;
        o_cause  = '0;
        if (i_exc_vec[EXC_FETCH_MIS])      o_cause = CAUSE_FETCH_MIS;
        else if (i_exc_vec[EXC_ILLEGAL])   o_cause = CAUSE_ILLEGAL;
        else if (i_exc_vec[EXC_EBREAK])    o_cause = CAUSE_EBREAK;
        else if (i_exc_vec[EXC_ECALL])     o_cause = CAUSE_ECALL;
        else if (i_exc_vec[EXC_LOAD_MIS])  o_cause = CAUSE_LOAD_MIS;
        else if (i_exc_vec[EXC_STORE_MIS]) o_cause = CAUSE_STORE_MIS;
        else begin
            o_is_irq = 1'b1;
            if (i_mstatus_mie && i_mie[IRQ_MEI_BIT] && i_irq_meip)      o_cause = CAUSE_IRQ_MEI;
            else if (i_mstatus_mie && i_mie[IRQ_MSI_BIT] && i_irq_msip) o_cause = CAUSE_IRQ_MSI;
            else if (i_mstatus_mie && i_mie[IRQ_MTI_BIT] && i_irq_mtip) o_cause = CAUSE_IRQ_MTI;
            else begin
                o_valid  = 1'b0;
                o_is_irq = 1'b0;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: flush, drain, CSR pulse, then PC redirect handshake.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets for mtvec mode 1.
//
// state      | meaning
// IDLE       | accept one event per cycle (exception > mret > interrupt)
// DRAIN_T    | flushing for a trap, wait pipe_drained
// ENTER      | trap_taken pulse with latched cause/pc/tval
// DRAIN_M    | flushing for mret, wait pipe_drained
// MRET       | mret_exec pulse, capture mepc
// REDIRECT   | hold redirect until fetch accepts
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [EXC_W-1:0] i_exc_vec,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic            i_irq_meip,
    input  logic            i_irq_msip,
    input  logic            i_irq_mtip,
    input  logic            i_mstatus_mie,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_irq_pc,
    input  logic            i_mret_req,
    input  logic [XLEN-1:0] i_mtvec_base,
    input  logic [1:0]      i_mtvec_mode,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_pipe_drained,
    input  logic            i_redirect_ready,
    output logic            o_trap_taken,
    output logic            o_mret_exec,
    output logic [XLEN-1:0] o_trap_pc,
    output logic [XLEN-1:0] o_trap_cause,
    output logic [XLEN-1:0] o_trap_tval,
    output logic            o_flush,
    output logic            o_stall,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc
);

    trap_state_e     r_state;
    logic [XLEN-1:0] r_cause, r_pc, r_tval, r_redirect_pc;
    logic            r_trap_taken, r_mret_exec, r_flush, r_stall, r_redirect_valid;

    logic            w_valid, w_is_irq, w_vectored, w_idle_evt, w_unused;
    logic [31:0]     w_cause;
    logic [XLEN-1:0] w_exc_tval, w_trap_target;

    trap_prio_enc u_prio_enc (
        .i_exc_vec     (i_exc_vec),
        .i_irq_meip    (i_irq_meip),
        .i_irq_msip    (i_irq_msip),
        .i_irq_mtip    (i_irq_mtip),
        .i_mstatus_mie (i_mstatus_mie),
        .i_mie         (i_mie),
        .o_valid       (w_valid),
        .o_is_irq      (w_is_irq),
        .o_cause       (w_cause)
    );

    assign w_unused = ^{i_mtvec_base[1:0], i_mtvec_mode};

`ifdef TRAP_VECTORED_EN
    assign w_vectored = (i_mtvec_mode == 2'b01) && r_cause[XLEN-1];
`else
    assign w_vectored = 1'b0;
`endif

    assign w_trap_target = {i_mtvec_base[XLEN-1:2], 2'b00}
                         + (w_vectored ? {r_cause[XLEN-3:0], 2'b00} : '0);
    assign w_exc_tval    = (w_cause == CAUSE_EBREAK || w_cause == CAUSE_ECALL) ? '0 : i_exc_tval;
    assign w_idle_evt    = (r_state == S_IDLE) && (w_valid || i_mret_req);

    // Kill must reach the pipeline in the commit cycle itself, so the event path bypasses the register.
    assign o_flush          = r_flush | (w_idle_evt & rst_n);
    assign o_stall          = r_stall;
    assign o_trap_taken     = r_trap_taken;
    assign o_mret_exec      = r_mret_exec;
    assign o_trap_pc        = r_pc;
    assign o_trap_cause     = r_cause;
    assign o_trap_tval      = r_tval;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_cause          <= '0;
            r_pc             <= '0;
            r_tval           <= '0;
            r_redirect_pc    <= '0;
            r_trap_taken     <= 1'b0;
            r_mret_exec      <= 1'b0;
            r_flush          <= 1'b0;
            r_stall          <= 1'b0;
            r_redirect_valid <= 1'b0;
        end else begin
            r_trap_taken <= 1'b0;
            r_mret_exec  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid && !w_is_irq) begin
                        r_cause <= w_cause;
                        r_pc    <= i_exc_pc;
                        r_tval  <= w_exc_tval;
                        r_flush <= 1'b1;
                        r_stall <= 1'b1;
                        r_state <= S_DRAIN_T;
                    end else if (i_mret_req) begin
                        r_flush <= 1'b1;
                        r_stall <= 1'b1;
                        r_state <= S_DRAIN_M;
                    end else if (w_valid) begin
                        r_cause <= w_cause;
                        r_pc    <= i_irq_pc;
                        r_tval  <= '0;
                        r_flush <= 1'b1;
                        r_stall <= 1'b1;
                        r_state <= S_DRAIN_T;
                    end
                end
                S_DRAIN_T: begin
                    if (i_pipe_drained) begin
                        r_flush      <= 1'b0;
                        r_trap_taken <= 1'b1;
                        r_state      <= S_ENTER;
                    end
                end
                S_ENTER: begin
                    r_redirect_pc    <= w_trap_target;
                    r_redirect_valid <= 1'b1;
                    r_state          <= S_REDIRECT;
                end
                S_DRAIN_M: begin
                    if (i_pipe_drained) begin
                        r_flush     <= 1'b0;
                        r_mret_exec <= 1'b1;
                        r_state     <= S_MRET;
                    end
                end
                S_MRET: begin
                    r_redirect_pc    <= i_mepc;
                    r_redirect_valid <= 1'b1;
                    r_state          <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    if (i_redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_redirect_pc    <= '0;
                        r_stall          <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: begin
                    r_flush          <= 1'b0;
                    r_stall          <= 1'b0;
                    r_redirect_valid <= 1'b0;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule
